// File: rtl/key_sched_ctrl256.sv
// Iterative AES-256 key expansion into a 15-entry round-key store with an indexed, registered read port.
// One 32-bit SubWord path produces one 128-bit round key per cycle for n = 2..14.
module key_sched_ctrl256 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic         rk_rd_en,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_data,
    output logic         rk_data_vld
);
    localparam int NR    = 14;
    localparam int KEY_W = 256;
    localparam int RK_W  = 128;

    // AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_READY  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_n;
    logic              r_done;
    logic              r_keys_valid;
    logic [RK_W-1:0]   r_rk [0:NR];
    logic [RK_W-1:0]   r_rk_data;
    logic              r_rk_data_vld;

    logic              w_key_ready;
    logic              w_busy;
    logic              w_accept;
    logic [RK_W-1:0]   w_prev1;
    logic [RK_W-1:0]   w_prev2;
    logic [RK_W-1:0]   w_rd_word;
    logic [31:0]       w_t;
    logic [31:0]       w_sub_in;
    logic [31:0]       w_sub_out;
    logic [7:0]        w_rcon;
    logic [31:0]       w_g;
    logic [31:0]       w_b0;
    logic [31:0]       w_b1;
    logic [31:0]       w_b2;
    logic [31:0]       w_b3;
    logic [RK_W-1:0]   w_rk_new;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    // FSM: state register and next-state / handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_key_ready = (r_state != S_EXPAND);
        w_busy      = (r_state == S_EXPAND);
        w_accept    = key_valid & w_key_ready;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_EXPAND;
            S_EXPAND: if (r_n == 4'(NR)) w_next = S_READY;
            S_READY:  if (w_accept) w_next = S_EXPAND;
            default:  w_next = S_IDLE;
        endcase
    end

    // Round counter and completion flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n          <= 4'd0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_n          <= 4'd2;
                r_keys_valid <= 1'b0;
            end else if (r_state == S_EXPAND) begin
                if (r_n == 4'(NR)) begin
                    r_n          <= 4'd0;
                    r_done       <= 1'b1;
                    r_keys_valid <= 1'b1;
                end else begin
                    r_n <= r_n + 4'd1;
                end
            end
        end
    end

    // Operand selection: rk[n-1], rk[n-2] and the read-port word
    always_comb begin
        w_prev1   = '0;
        w_prev2   = '0;
        w_rd_word = '0;
        for (int i = 0; i <= NR; i++) begin
            if (r_n == 4'(i + 1)) w_prev1 = r_rk[i];
            if (r_n == 4'(i + 2)) w_prev2 = r_rk[i];
            if (rk_idx == 4'(i))  w_rd_word = r_rk[i];
        end
    end

    // Even rounds rotate and add Rcon; odd rounds only substitute.
    always_comb begin
        w_t       = w_prev1[31:0];
        w_sub_in  = r_n[0] ? w_t : {w_t[23:0], w_t[31:24]};
        w_sub_out = {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]),
                     sbox(w_sub_in[15:8]),  sbox(w_sub_in[7:0])};
        w_rcon    = 8'h01 << (r_n[3:1] - 3'd1);
        w_g       = w_sub_out ^ (r_n[0] ? 32'h0 : {w_rcon, 24'h0});
        w_b0      = w_prev2[127:96] ^ w_g;
        w_b1      = w_prev2[95:64]  ^ w_b0;
        w_b2      = w_prev2[63:32]  ^ w_b1;
        w_b3      = w_prev2[31:0]   ^ w_b2;
        w_rk_new  = {w_b0, w_b1, w_b2, w_b3};
    end

    // Round-key store; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rk[0] <= key_in[KEY_W-1:RK_W];
            r_rk[1] <= key_in[RK_W-1:0];
        end else if (r_state == S_EXPAND) begin
            for (int i = 2; i <= NR; i++) begin
                if (r_n == 4'(i)) r_rk[i] <= w_rk_new;
            end
        end
    end

    // Read port samples the store before any same-edge overwrite by a re-key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rk_data     <= '0;
            r_rk_data_vld <= 1'b0;
        end else begin
            r_rk_data_vld <= 1'b0;
            if (rk_rd_en && r_keys_valid) begin
                r_rk_data     <= w_rd_word;
                r_rk_data_vld <= 1'b1;
            end
        end
    end

    assign key_ready   = w_key_ready;
    assign busy        = w_busy;
    assign done        = r_done;
    assign keys_valid  = r_keys_valid;
    assign rk_data     = r_rk_data;
    assign rk_data_vld = r_rk_data_vld;

endmodule

// File: tb/tb_key_sched_ctrl256.sv
// Directed bench for key_sched_ctrl256 using FIPS-197 AES-256 key-expansion vectors.
// Reads push expected words into exp_q; a negedge monitor pops on every rk_data_vld.
module tb_key_sched_ctrl256;

  logic         clk;
  logic         rst_n;
  logic [255:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic         rk_rd_en;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         rk_data_vld;

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] exp_q[$];

  logic [255:0] key_c3;
  logic [255:0] key_a3;
  logic [127:0] rk_c3 [15];
  logic [127:0] rk_a3_2;
  logic [127:0] rk_a3_14;

  key_sched_ctrl256 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .busy        (busy),
    .done        (done),
    .keys_valid  (keys_valid),
    .rk_rd_en    (rk_rd_en),
    .rk_idx      (rk_idx),
    .rk_data     (rk_data),
    .rk_data_vld (rk_data_vld)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // driver tasks
  task automatic load_key(input logic [255:0] k);
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx, input logic [127:0] exp);
    rk_rd_en = 1'b1;
    rk_idx   = idx;
    exp_q.push_back(exp);
    tick();
    rk_rd_en = 1'b0;
  endtask

  task automatic wait_done(input int exp_cyc, input string name);
    int cyc = 0;
    bit kv_early = 1'b0;
    while (!done && cyc < 40) begin
      if (keys_valid) kv_early = 1'b1;
      tick();
      cyc++;
    end
    chk({name, " done latency"}, 128'(cyc), 128'(exp_cyc));
    chk({name, " keys_valid low while expanding"}, 128'(kv_early), 128'd0);
    chk({name, " keys_valid at done"}, 128'(keys_valid), 128'd1);
    chk({name, " busy at done"}, 128'(busy), 128'd0);
    chk({name, " key_ready at done"}, 128'(key_ready), 128'd1);
    tick();
    chk({name, " done is a pulse"}, 128'(done), 128'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && rk_data_vld) begin
      if (exp_q.size() == 0) chk("unexpected rk_data_vld", 128'd1, 128'd0);
      else                   chk("rk_data", rk_data, exp_q.pop_front());
    end
  end

  initial begin
    key_c3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    key_a3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    rk_c3 = '{
      128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f,
      128'ha573c29fa176c498a97fce93a572c09c, 128'h1651a8cd0244beda1a5da4c10640bade,
      128'hae87dff00ff11b68a68ed5fb03fc1567, 128'h6de1f1486fa54f9275f8eb5373b8518d,
      128'hc656827fc9a799176f294cec6cd5598b, 128'h3de23a75524775e727bf9eb45407cf39,
      128'h0bdc905fc27b0948ad5245a4c1871c2f, 128'h45f5a66017b2d387300d4d33640a820a,
      128'h7ccff71cbeb4fe5413e6bbf0d261a7df, 128'hf01afafee7a82979d7a5644ab3afe640,
      128'h2541fe719bf500258813bbd55a721c0a, 128'h4e5a6699a9f24fe07e572baacdf8cdea,
      128'h24fc79ccbf0979e9371ac23c6d68de36
    };
    rk_a3_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    rk_a3_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    key_in    = '0;
    key_valid = 1'b0;
    rk_rd_en  = 1'b0;
    rk_idx    = 4'd0;
    do_reset();

    // reset state
    chk("reset key_ready", 128'(key_ready), 128'd1);
    chk("reset busy", 128'(busy), 128'd0);
    chk("reset done", 128'(done), 128'd0);
    chk("reset keys_valid", 128'(keys_valid), 128'd0);
    chk("reset rk_data", rk_data, 128'd0);
    chk("reset rk_data_vld", 128'(rk_data_vld), 128'd0);

    // C.3 key: latency and schedule
    load_key(key_c3);
    chk("c3 busy after accept", 128'(busy), 128'd1);
    chk("c3 key_ready after accept", 128'(key_ready), 128'd0);
    wait_done(13, "c3");
    rd(4'd0, rk_c3[0]);
    rd(4'd1, rk_c3[1]);
    rd(4'd2, rk_c3[2]);
    rd(4'd14, rk_c3[14]);
    tick();

    // A.3 key re-keyed from READY
    load_key(key_a3);
    chk("a3 keys_valid falls on re-key", 128'(keys_valid), 128'd0);
    wait_done(13, "a3");
    rd(4'd2, rk_a3_2);
    rd(4'd14, rk_a3_14);
    tick();

    // accept C.3 while reading idx 14 of the A.3 schedule
    key_in    = key_c3;
    key_valid = 1'b1;
    rk_rd_en  = 1'b1;
    rk_idx    = 4'd14;
    exp_q.push_back(rk_a3_14);
    tick();
    key_valid = 1'b0;
    rk_rd_en  = 1'b0;
    chk("rekey busy", 128'(busy), 128'd1);
    wait_done(13, "rekey");
    for (int i = 0; i < 15; i++) rd(4'(i), rk_c3[i]);
    rd(4'd15, 128'd0);
    tick();

    // key_valid and reads ignored while expanding
    load_key(key_c3);
    key_in    = key_a3;
    key_valid = 1'b1;
    rk_rd_en  = 1'b1;
    rk_idx    = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy key_ready low", 128'(key_ready), 128'd0);
      chk("busy no read data", 128'(rk_data_vld), 128'd0);
    end
    key_valid = 1'b0;
    rk_rd_en  = 1'b0;
    wait_done(10, "ignore");
    rd(4'd14, rk_c3[14]);
    rd(4'd5, rk_c3[5]);
    tick();

    // reset in the middle of expansion
    load_key(key_a3);
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midreset busy", 128'(busy), 128'd0);
    chk("midreset key_ready", 128'(key_ready), 128'd1);
    chk("midreset keys_valid", 128'(keys_valid), 128'd0);
    chk("midreset rk_data", rk_data, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    load_key(key_c3);
    wait_done(13, "after reset");
    for (int i = 0; i < 15; i++) rd(4'(i), rk_c3[i]);

    for (int i = 0; i < 4; i++) tick();
    chk("scoreboard drained", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
